// File: rtl/vecmat_row_collect.sv
// vecmat_row_collect: tile accumulation with saturation and row packing
// Collects per-column dot-product results into packed rows with one spare row buffer.
module vecmat_row_collect #(
    parameter int DATA_WIDTH = 16,
    parameter int VECT_DEPTH = 32,
    parameter int NUM_TILES  = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH*VECT_DEPTH-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_sat
);

    localparam int RW = DATA_WIDTH * VECT_DEPTH;
    localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int EW = (VECT_DEPTH > 1) ? $clog2(VECT_DEPTH) : 1;

    localparam logic [TW-1:0] TILE_LAST = TW'(NUM_TILES - 1);
    localparam logic [EW-1:0] ELEM_LAST = EW'(VECT_DEPTH - 1);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] FULL    = 1'b1;

    logic [0:0]            state;
    logic [TW-1:0]         tile_cnt;
    logic [EW-1:0]         elem_cnt;
    logic [DATA_WIDTH-1:0] acc;
    logic [RW-1:0]         coll;
    logic                  sat_flag;
    logic                  buf_sat;

    logic                  accept;
    logic                  first_tile;
    logic                  last_tile;
    logic                  last_elem;
    logic                  row_done;
    logic                  out_free;
    logic [DATA_WIDTH:0]   sum;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] sat_val;
    logic [DATA_WIDTH-1:0] elem_val;
    logic                  clamp;
    logic                  row_sat;
    logic [RW-1:0]         row_next;

    assign in_ready   = (state == COLLECT) && !reset;
    assign accept     = in_valid && in_ready;
    assign first_tile = (tile_cnt == '0);
    assign last_tile  = (tile_cnt == TILE_LAST);
    assign last_elem  = (elem_cnt == ELEM_LAST);
    assign row_done   = accept && last_tile && last_elem;
    assign out_free   = !out_valid || out_ready;

    // Saturating 17-bit add of the running partial and the incoming partial
    always_comb begin
        sum      = {acc[DATA_WIDTH-1], acc} + {in_data[DATA_WIDTH-1], in_data};
        ovf      = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
        sat_val  = sum[DATA_WIDTH-1:0];
        if (ovf) begin
            sat_val = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
        elem_val = first_tile ? in_data : sat_val;
        clamp    = accept && !first_tile && ovf;
        row_sat  = sat_flag || clamp;
    end

    // Completed row as it will look once the final slot is written
    always_comb begin
        row_next = coll;
        row_next[int'(elem_cnt)*DATA_WIDTH +: DATA_WIDTH] = elem_val;
    end

    // Counters, accumulator, collection slots and row-local saturation flag
    always_ff @(posedge clk) begin
        if (reset) begin
            tile_cnt <= '0;
            elem_cnt <= '0;
            acc      <= '0;
            coll     <= '0;
            sat_flag <= 1'b0;
        end else if (accept) begin
            tile_cnt <= last_tile ? '0 : tile_cnt + 1'b1;
            if (last_tile) begin
                coll[int'(elem_cnt)*DATA_WIDTH +: DATA_WIDTH] <= elem_val;
                elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
            end else begin
                acc <= elem_val;
            end
            sat_flag <= row_done ? 1'b0 : row_sat;
        end
    end

    // Output register and spare-row state: load, park or drain
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            buf_sat   <= 1'b0;
        end else if (row_done && out_free) begin
            out_data  <= row_next;
            out_sat   <= row_sat;
            out_valid <= 1'b1;
        end else if (row_done) begin
            state   <= FULL;
            buf_sat <= row_sat;
        end else if (state == FULL && out_ready) begin
            out_data <= coll;
            out_sat  <= buf_sat;
            state    <= COLLECT;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vecmat_row_collect.sv
// tb_vecmat_row_collect: directed table vectors, corner sequences, random stress
// Two instances: single-tile (scoreboarded) and two-tile (saturation table).
module tb_vecmat_row_collect;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  in_data1 = '0;
    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [511:0] out_data1;
    logic         out_valid1;
    logic         out_ready1 = 1'b0;
    logic         out_sat1;
    logic [15:0]  in_data2 = '0;
    logic         in_valid2 = 1'b0;
    logic         in_ready2;
    logic [511:0] out_data2;
    logic         out_valid2;
    logic         out_ready2 = 1'b0;
    logic         out_sat2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vecmat_row_collect #(.DATA_WIDTH(16), .VECT_DEPTH(32), .NUM_TILES(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_sat(out_sat1)
    );

    vecmat_row_collect #(.DATA_WIDTH(16), .VECT_DEPTH(32), .NUM_TILES(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_sat(out_sat2)
    );

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard for dut1: rows of accepted beats vs. handshaked rows
    logic [511:0] exp_q[$];
    logic [511:0] cur_row = '0;
    int           sb_n = 0;
    int           sb_rows = 0;
    logic         prev_v = 1'b0;
    logic         prev_r = 1'b0;
    logic         prev_rst = 1'b1;
    logic [511:0] prev_d = '0;
    logic         prev_s = 1'b0;

    always @(negedge clk) begin
        if (!prev_rst && prev_v && !prev_r) begin
            chk("hold_valid", out_valid1, 1'b1);
            chk("hold_data", out_data1, prev_d);
            chk("hold_sat", out_sat1, prev_s);
        end
        if (reset) begin
            sb_n = 0;
            exp_q.delete();
        end else begin
            if (out_valid1 && out_ready1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_row", out_valid1, 1'b0);
                end else begin
                    chk("sb_row", out_data1, exp_q.pop_front());
                    chk("sb_sat", out_sat1, 1'b0);
                    sb_rows++;
                end
            end
            if (in_valid1 && in_ready1) begin
                cur_row[sb_n*16 +: 16] = in_data1;
                sb_n++;
                if (sb_n == 32) begin
                    exp_q.push_back(cur_row);
                    sb_n = 0;
                end
            end
        end
        prev_v   = out_valid1;
        prev_r   = out_ready1;
        prev_rst = reset;
        prev_d   = out_data1;
        prev_s   = out_sat1;
    end

    typedef struct {
        logic [15:0] e0a, e0b, e1a, e1b, ra, rb, la, lb;
        logic [15:0] x0, x1, xr, xl;
        logic        xs;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [511:0] row_a;
        logic [511:0] row_b;
        logic [511:0] erow;
        logic [15:0]  d;
        int           base;
        int           target;
        int           cyc;

        tbl[0] = '{16'h4000, 16'h4000, 16'h8001, 16'hFFFE, 16'h0001, 16'h0002,
                   16'h0001, 16'h0002, 16'h7FFF, 16'h8000, 16'h0003, 16'h0003, 1'b1};
        tbl[1] = '{16'h0010, 16'h0020, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0002,
                   16'h0001, 16'h0002, 16'h0030, 16'hFFFE, 16'h0003, 16'h0003, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 16'h8000, 16'hFFFF, 16'h0005, 16'hFFFB,
                   16'h0005, 16'hFFFB, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 1'b1};
        tbl[3] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h1234, 16'h0000,
                   16'h1234, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h1234, 1'b0};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h6000, 16'h6000,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001,
                   16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0002, 16'h8000, 1'b1};

        // Reset state
        repeat (3) tick();
        smp();
        chk("rst_in_ready", in_ready1, 1'b0);
        chk("rst_out_valid", out_valid1, 1'b0);
        chk("rst_out_data", out_data1, '0);
        chk("rst_out_sat", out_sat1, 1'b0);
        tick();
        reset = 1'b0;
        smp();
        chk("rel_in_ready", in_ready1, 1'b1);

        // Basic packing
        out_ready1 = 1'b1;
        erow = '0;
        for (int i = 0; i < 32; i++) begin
            tick();
            in_valid1 = 1'b1;
            in_data1  = 16'(i + 1);
            erow[i*16 +: 16] = 16'(i + 1);
            smp();
            if (i == 31) chk("pk_not_early", out_valid1, 1'b0);
        end
        tick();
        in_valid1 = 1'b0;
        smp();
        chk("pk_valid", out_valid1, 1'b1);
        chk("pk_data", out_data1, erow);
        chk("pk_sat", out_sat1, 1'b0);
        tick();
        smp();
        chk("pk_pulse", out_valid1, 1'b0);

        // Backpressure: row A held, row B parked, then stall
        out_ready1 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            in_valid1 = 1'b1;
            in_data1  = 16'(16'h0200 + i);
            if (i < 32) row_a[i*16 +: 16] = in_data1;
            else row_b[(i-32)*16 +: 16] = in_data1;
            smp();
            if (i == 63) chk("bp_rdy_before", in_ready1, 1'b1);
        end
        tick();
        in_data1 = 16'hDEAD;
        smp();
        chk("bp_stall_rdy", in_ready1, 1'b0);
        chk("bp_stall_valid", out_valid1, 1'b1);
        chk("bp_stall_data", out_data1, row_a);
        repeat (2) begin
            tick();
            smp();
            chk("bp_stall_rdy2", in_ready1, 1'b0);
        end
        tick();
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        smp();
        chk("bp_row1", out_data1, row_a);
        tick();
        smp();
        chk("bp_valid2", out_valid1, 1'b1);
        chk("bp_row2", out_data1, row_b);
        chk("bp_rdy_back", in_ready1, 1'b1);
        tick();
        smp();
        chk("bp_drain", out_valid1, 1'b0);

        // Continuous 96 beats with out_ready high
        base = sb_rows;
        for (int i = 0; i < 96; i++) begin
            tick();
            in_valid1 = 1'b1;
            in_data1  = 16'(16'h0300 + i);
            smp();
            chk($sformatf("cont_valid_%0d", i), out_valid1, (i == 32 || i == 64));
        end
        tick();
        in_valid1 = 1'b0;
        smp();
        chk("cont_last_valid", out_valid1, 1'b1);
        tick();
        smp();
        chk("cont_drain", out_valid1, 1'b0);
        chk("cont_rows", sb_rows - base, 3);

        // Row completion in the same cycle as the output handshake
        out_ready1 = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick();
            in_valid1 = 1'b1;
            in_data1  = (i < 32) ? 16'(16'h0400 + i) : 16'(16'h0500 + i - 32);
            if (i >= 32) row_b[(i-32)*16 +: 16] = in_data1;
        end
        tick();
        in_data1   = 16'h051F;
        row_b[31*16 +: 16] = 16'h051F;
        out_ready1 = 1'b1;
        smp();
        chk("sim_valid", out_valid1, 1'b1);
        chk("sim_rdy", in_ready1, 1'b1);
        tick();
        in_valid1 = 1'b0;
        smp();
        chk("sim_valid2", out_valid1, 1'b1);
        chk("sim_row", out_data1, row_b);
        chk("sim_not_full", in_ready1, 1'b1);
        tick();
        smp();
        chk("sim_drain", out_valid1, 1'b0);

        // Reset mid-row
        for (int i = 0; i < 10; i++) begin
            tick();
            in_valid1 = 1'b1;
            in_data1  = 16'(16'h0600 + i);
        end
        tick();
        in_valid1 = 1'b0;
        reset     = 1'b1;
        smp();
        chk("mr_rdy_in_reset", in_ready1, 1'b0);
        tick();
        reset = 1'b0;
        smp();
        chk("mr_valid", out_valid1, 1'b0);
        chk("mr_rdy", in_ready1, 1'b1);
        for (int i = 0; i < 32; i++) begin
            tick();
            in_valid1 = 1'b1;
            in_data1  = 16'h0100;
            erow[i*16 +: 16] = 16'h0100;
            smp();
            chk($sformatf("mr_no_row_%0d", i), out_valid1, 1'b0);
        end
        tick();
        in_valid1 = 1'b0;
        smp();
        chk("mr_row_valid", out_valid1, 1'b1);
        chk("mr_row", out_data1, erow);
        tick();
        smp();

        // Reset while the spare row is occupied
        out_ready1 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            in_valid1 = 1'b1;
            in_data1  = 16'(16'h0700 + i);
        end
        tick();
        in_valid1 = 1'b0;
        smp();
        chk("rf_full", in_ready1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        smp();
        chk("rf_valid", out_valid1, 1'b0);
        chk("rf_data", out_data1, '0);
        chk("rf_rdy", in_ready1, 1'b1);

        // Two-tile accumulation and saturation table
        out_ready2 = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int e = 0; e < 32; e++) begin
                for (int t = 0; t < 2; t++) begin
                    if (e == 0) d = t ? tbl[v].e0b : tbl[v].e0a;
                    else if (e == 1) d = t ? tbl[v].e1b : tbl[v].e1a;
                    else if (e == 31) d = t ? tbl[v].lb : tbl[v].la;
                    else d = t ? tbl[v].rb : tbl[v].ra;
                    tick();
                    in_valid2 = 1'b1;
                    in_data2  = d;
                end
                if (e == 0) erow[15:0] = tbl[v].x0;
                else if (e == 1) erow[31:16] = tbl[v].x1;
                else if (e == 31) erow[511:496] = tbl[v].xl;
                else erow[e*16 +: 16] = tbl[v].xr;
            end
            tick();
            in_valid2 = 1'b0;
            smp();
            chk($sformatf("tv%0d_valid", v), out_valid2, 1'b1);
            chk($sformatf("tv%0d_row", v), out_data2, erow);
            chk($sformatf("tv%0d_sat", v), out_sat2, tbl[v].xs);
            tick();
            smp();
            chk($sformatf("tv%0d_drain", v), out_valid2, 1'b0);
        end

        // Random stress on the single-tile instance
        target = sb_rows + 200;
        cyc = 0;
        while (sb_rows < target && cyc < 40000) begin
            tick();
            in_valid1  = 1'($urandom_range(0, 1));
            in_data1   = 16'($urandom);
            out_ready1 = 1'($urandom_range(0, 1));
            cyc++;
        end
        chk("stress_rows_done", (sb_rows >= target), 1'b1);
        tick();
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        repeat (4) tick();
        smp();
        chk("stress_queue_empty", exp_q.size(), 0);
        chk("stress_drained", out_valid1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
